// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one rectangular 4-bit palette-indexed sprite from a
// synchronous sprite ROM into the frame buffer, one pixel per clock. Pixels
// whose colour equals KEY are skipped, and pixels that land off-screen are clipped.
//
// Optional feature macro: BLIT_FLIP_EN
//   When it is defined, the flip input mirrors the sprite horizontally.
//   When it is undefined, flip is ignored and the mirror logic is not built.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start; latches position, base address and flip
//   RUN   | issues one ROM read per clock, in row-major order
//   DRAIN | write stage for the last ROM read
//   DONE  | one-cycle done pulse; busy is already low
module sprite_blitter #(
    parameter int          SCREEN_W = 640,
    parameter int          SCREEN_H = 480,
    parameter int          SPR_W    = 64,
    parameter int          SPR_H    = 64,
    parameter int          ROM_AW   = 16,
    parameter logic [3:0]  KEY      = 4'h0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic signed [10:0]       sprite_x,
    input  logic signed [10:0]       sprite_y,
    input  logic [ROM_AW-1:0]        sprite_base,
    input  logic                     flip,
    output logic                     busy,
    output logic                     done,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [3:0]               rom_data,
    output logic [31:0]              fb_addr,
    output logic [3:0]               fb_data,
    output logic                     fb_we
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    // 13-bit signed coordinates leave headroom above sprite_x + SPR_W
    localparam logic signed [12:0] SCR_W = 13'(SCREEN_W);
    localparam logic signed [12:0] SCR_H = 13'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic signed [10:0]     x_lat;
    logic signed [10:0]     y_lat;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col_term;
    logic signed [12:0]     x_rd;
    logic signed [12:0]     y_rd;
    logic                   s1_valid;
    logic signed [12:0]     s1_x;
    logic signed [12:0]     s1_y;
    logic                   pix_ok;
    logic [31:0]            wr_addr;

`ifdef BLIT_FLIP_EN
    logic                   flip_lat;
    assign col_term = flip_lat ? (COL_LAST - col) : col;
`else
    logic                   flip_unused;
    assign flip_unused = flip;
    assign col_term    = col;
`endif

    // Screen coordinate of the pixel being read this cycle
    assign x_rd = 13'(x_lat) + $signed({1'b0, 12'(col_term)});
    assign y_rd = 13'(y_lat) + $signed({1'b0, 12'(row)});

    // Write decision for the pixel whose ROM data is arriving this cycle
    assign pix_ok = s1_valid
                 && (s1_x >= 13'sd0) && (s1_x < SCR_W)
                 && (s1_y >= 13'sd0) && (s1_y < SCR_H)
                 && (rom_data != KEY);
    assign wr_addr = 32'(s1_y) * 32'(SCREEN_W) + 32'(s1_x);

    // Sequencer: parameter latch, read-address walk and the one-deep coordinate pipeline
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_addr <= '0;
            col      <= '0;
            row      <= '0;
            x_lat    <= '0;
            y_lat    <= '0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
`ifdef BLIT_FLIP_EN
            flip_lat <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            s1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_lat    <= sprite_x;
                        y_lat    <= sprite_y;
                        rom_addr <= sprite_base;
`ifdef BLIT_FLIP_EN
                        flip_lat <= flip;
`endif
                        col      <= '0;
                        row      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s1_valid <= 1'b1;
                    s1_x     <= x_rd;
                    s1_y     <= y_rd;
                    // Row-major storage means the ROM address is a simple increment
                    rom_addr <= rom_addr + ROM_AW'(1);
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            state <= DRAIN;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered frame-buffer write port
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= pix_ok;
            if (pix_ok) begin
                fb_addr <= wr_addr;
                fb_data <= rom_data;
            end
        end
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copies one rectangular 4-bit palette-indexed sprite from a synchronous sprite ROM into the 640×480 frame buffer, one pixel per clock. It sits directly upstream of the frame-buffer RAM and drives its write port (write address, write data, write enable). The game logic issues one start pulse per sprite per frame. Colour-key pixels are skipped, and pixels falling off-screen are clipped.

## Interface
Parameters:
- SCREEN_W, 640, frame width in pixels
- SCREEN_H, 480, frame height in pixels
- SPR_W, 64, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- ROM_AW, 16, sprite ROM address width
- KEY, 4'h0, transparent colour index

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- sprite_x  in  11 signed  screen X of sprite top-left; may be negative
- sprite_y  in  11 signed  screen Y of sprite top-left; may be negative
- sprite_base  in  ROM_AW  ROM address of sprite pixel (0,0), row-major
- flip  in  1  horizontal mirror request
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse when a blit completes
- rom_addr  out  ROM_AW  sprite ROM read address
- rom_data  in  4  ROM data, valid exactly 1 cycle after rom_addr
- fb_addr  out  32  frame-buffer write address
- fb_data  out  4  frame-buffer write data
- fb_we  out  1  frame-buffer write enable

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - When start=1, latch sprite_x, sprite_y, sprite_base and flip.
  - Clear col and row to 0, then go to RUN.
- RUN:
  - Each cycle, drive rom_addr = sprite_base + row*SPR_W + col (mod 2^ROM_AW).
  - Advance col. When col wraps to 0, increment row.
  - After issuing (col=SPR_W-1, row=SPR_H-1), go to DRAIN.
- Write stage (one cycle behind each read): the ROM address and the screen coordinate are pipelined alongside the read.
  - Screen X = sprite_x + (flip ? SPR_W-1-col : col). Screen Y = sprite_y + row.
  - fb_we=1 only if 0≤X<SCREEN_W, 0≤Y<SCREEN_H and rom_data≠KEY.
  - When written: fb_addr = Y*SCREEN_W + X, zero-extended to 32 bits; fb_data = rom_data.
- DRAIN: performs the final write stage, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, then goes to IDLE.
- start is ignored outside IDLE; parameters are not re-latched mid-blit.
- Coordinate arithmetic is at least 12-bit signed, so sprite_x+SPR_W never overflows.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0.
  - The pipeline valid bit is cleared, so no stray write occurs after reset releases.

## Timing
- Let N = SPR_W*SPR_H, and let cycle 0 be the cycle in which start is sampled.
- busy rises at cycle 1 and stays high through cycle N+1.
- ROM reads occur in cycles 1..N. Writes are possible in cycles 2..N+1.
- done pulses in cycle N+2. busy is 0 in that cycle.
- Throughput is one pixel per clock, with no stalls.
- The earliest next start is accepted in cycle N+3.
- fb_we, fb_addr and fb_data are registered outputs. They change only on Clk rising edges or on reset.

## Configuration
- BLIT_FLIP_EN defined: the flip input mirrors the sprite horizontally as described in Operation.
- BLIT_FLIP_EN undefined:
  - The flip input is ignored; X = sprite_x + col always.
  - The flip latch and mirror subtractor are not synthesised.
  - Cycle timing is identical either way.

## Test plan
- Unclipped blit. SPR_W=SPR_H=4 override, sprite at (10,20), ROM filled with 1..15 plus one KEY pixel.
  - Exactly 15 writes.
  - First write is fb_addr 12810 with data = ROM[base].
  - done at cycle 18.
- Transparency. All-KEY sprite → fb_we never asserts; busy lasts N+1 cycles; done still pulses at cycle N+2.
- Clipping at negative and far edges.
  - Sprite at (-2,-1) with 4×4: only columns 2..3 of rows 1..3 are written (6 writes, first at fb_addr 0).
  - Sprite at (638,478): only 4 pixels are written; last fb_addr = 307199.
- Flip (macro on). flip=1 at (0,0), row 0 = {1,2,3,4} → fb_addr 0..3 receive 4,3,2,1. With the macro off, they receive 1,2,3,4.
- Busy behaviour. start asserted again mid-blit with new coordinates → ignored; all writes use the original latch; a single done pulse.
- Reset mid-operation. Reset_n low at cycle 5 → fb_we and busy go 0 immediately; no writes after release; a new start at (0,0) completes normally.
